// File: rtl/timer_pkg.sv
// Shared constants for the timer tick divider: output mode encodings,
// the power-on divisor and the LOAD_CH select-width helper.
package timer_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned TIMER_DEFAULT_DIV = 100000;

  // Width of a channel select field; never narrower than one bit.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/timer_div_channel.sv
// One divider channel: divisor register, free-running counter, registered
// terminal-count tick and the divided output (square wave or pulse).
module timer_div_channel
  import timer_pkg::*;
#(
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = TIMER_DEFAULT_DIV
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  logic             mode_q;
  logic             term;
  logic             toggle_base;

  // div is never zero, so div-1 cannot underflow. The >= compare makes any
  // counter value at or above the last count behave as terminal, so the
  // counter can never run past div-1.
  assign div_m1 = div - CNT_W'(1);
  assign term   = en && (cnt >= div_m1);

  // Leaving pulse mode restarts the square wave from a low level.
  assign toggle_base = (mode_q == MODE_PULSE) ? 1'b0 : clk_out;

  // Divisor/counter update, terminal-count tick and divided output.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      div     <= CNT_W'(DEFAULT_DIV);
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      mode_q  <= MODE_TOGGLE;
    end else begin
      mode_q <= mode;
      if (load) begin
        // A load overrides a coincident terminal count: no tick, no toggle.
        div     <= load_div;
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= (mode == MODE_PULSE) ? 1'b0 : toggle_base;
      end else begin
        tick <= term;
        if (en) begin
          cnt <= term ? '0 : cnt + CNT_W'(1);
        end
        if (mode == MODE_PULSE) begin
          clk_out <= term;
        end else begin
          clk_out <= toggle_base ^ term;
        end
      end
    end
  end

endmodule

// File: rtl/timer_tick_divider.sv
// Multi-channel timer tick divider: decodes divisor loads, flags rejected
// loads on LOAD_ERR and instantiates one divider channel per output.
module timer_tick_divider
  import timer_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = TIMER_DEFAULT_DIV,
  localparam int         CH_W        = ch_sel_w(NUM_CH)
) (
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic [NUM_CH-1:0] MODE,
  input  logic              LOAD,
  input  logic [CH_W-1:0]   LOAD_CH,
  input  logic [CNT_W-1:0]  LOAD_DIV,
  output logic              LOAD_ERR,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] CLK_OUT
);

  logic              ch_ok;
  logic              div_ok;
  logic              load_ok;
  logic [NUM_CH-1:0] load_hit;

  // One extra bit so NUM_CH itself is representable when NUM_CH is a power of two.
  assign ch_ok   = ({1'b0, LOAD_CH} < (CH_W+1)'(NUM_CH));
  assign div_ok  = (LOAD_DIV != '0);
  assign load_ok = LOAD && ch_ok && div_ok;

  // Rejected load flag, high for the cycle after the offending strobe.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      LOAD_ERR <= 1'b0;
    end else begin
      LOAD_ERR <= LOAD && !(ch_ok && div_ok);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_hit[i] = load_ok && (LOAD_CH == CH_W'(i));

    timer_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .CLK_IN   (CLK_IN),
      .RST_N    (RST_N),
      .en       (EN[i]),
      .mode     (MODE[i]),
      .load     (load_hit[i]),
      .load_div (LOAD_DIV),
      .tick     (TICK[i]),
      .clk_out  (CLK_OUT[i])
    );
  end

endmodule

// File: tb/tb_timer_tick_divider.sv
// Directed bench for timer_tick_divider. Three channels are instantiated so
// that LOAD_CH=3 is a representable, out-of-range channel select.
module tb_timer_tick_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 24;
  localparam int CH_W   = 2;

  logic              CLK_IN = 1'b0;
  logic              RST_N;
  logic [NUM_CH-1:0] EN;
  logic [NUM_CH-1:0] MODE;
  logic              LOAD;
  logic [CH_W-1:0]   LOAD_CH;
  logic [CNT_W-1:0]  LOAD_DIV;
  logic              LOAD_ERR;
  logic [NUM_CH-1:0] TICK;
  logic [NUM_CH-1:0] CLK_OUT;

  int total = 0;
  int bad   = 0;

  timer_tick_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (100000)
  ) dut (
    .CLK_IN   (CLK_IN),
    .RST_N    (RST_N),
    .EN       (EN),
    .MODE     (MODE),
    .LOAD     (LOAD),
    .LOAD_CH  (LOAD_CH),
    .LOAD_DIV (LOAD_DIV),
    .LOAD_ERR (LOAD_ERR),
    .TICK     (TICK),
    .CLK_OUT  (CLK_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_IN);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N    = 1'b0;
    EN       = '0;
    MODE     = '0;
    LOAD     = 1'b0;
    LOAD_CH  = '0;
    LOAD_DIV = '0;

    // Reset state
    #12;
    chk("rst_tick", 32'(TICK), 32'h0);
    chk("rst_clk_out", 32'(CLK_OUT), 32'h0);
    chk("rst_load_err", 32'(LOAD_ERR), 32'h0);
    chk("rst_div0", 32'(dut.g_ch[0].u_ch.div), 32'd100000);
    @(negedge CLK_IN);
    RST_N = 1'b1;

    // ch0 div=4, toggle mode: tick every 4 cycles, square wave of period 8
    LOAD = 1'b1; LOAD_CH = 2'd0; LOAD_DIV = 24'd4;
    cyc(1);
    LOAD = 1'b0; EN = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      chk($sformatf("b_tick0 k=%0d", k), 32'(TICK[0]), 32'((k % 4) == 0));
      chk($sformatf("b_clk0 k=%0d", k), 32'(CLK_OUT[0]), 32'((k / 4) % 2));
      chk($sformatf("b_static k=%0d", k), 32'({TICK[2:1], CLK_OUT[2:1]}), 32'h0);
    end

    // Pause ch0 at cnt=2 for 10 cycles, then resume
    cyc(2);
    chk("c_cnt0_before", 32'(dut.g_ch[0].u_ch.cnt), 32'd2);
    EN = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk($sformatf("c_hold_tick k=%0d", k), 32'(TICK[0]), 32'h0);
      chk($sformatf("c_hold_clk k=%0d", k), 32'(CLK_OUT[0]), 32'h0);
    end
    chk("c_cnt0_held", 32'(dut.g_ch[0].u_ch.cnt), 32'd2);
    EN = 3'b001;
    cyc(1);
    chk("c_resume_tick1", 32'(TICK[0]), 32'h0);
    cyc(1);
    chk("c_resume_tick2", 32'(TICK[0]), 32'h1);
    chk("c_resume_clk", 32'(CLK_OUT[0]), 32'h1);

    // ch1 pulse mode with div=1: tick and output high every cycle
    LOAD = 1'b1; LOAD_CH = 2'd1; LOAD_DIV = 24'd1;
    MODE = 3'b010; EN = 3'b010;
    cyc(1);
    LOAD = 1'b0;
    chk("d_load_edge_tick", 32'(TICK), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk($sformatf("d_tick k=%0d", k), 32'(TICK), 32'b010);
      chk($sformatf("d_clk k=%0d", k), 32'(CLK_OUT), 32'b011);
    end

    // Rejected loads: zero divisor, then out-of-range channel
    LOAD = 1'b1; LOAD_CH = 2'd0; LOAD_DIV = 24'd0;
    cyc(1);
    chk("e_err_div0", 32'(LOAD_ERR), 32'h1);
    LOAD_CH = 2'd3; LOAD_DIV = 24'd7;
    cyc(1);
    chk("e_err_ch3", 32'(LOAD_ERR), 32'h1);
    chk("e_ch1_unaffected", 32'(TICK[1]), 32'h1);
    LOAD = 1'b0;
    cyc(1);
    chk("e_err_clear", 32'(LOAD_ERR), 32'h0);
    chk("e_div0_kept", 32'(dut.g_ch[0].u_ch.div), 32'd4);
    EN = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("e_tick0 k=%0d", k), 32'(TICK[0]), 32'(k == 4));
      if (k == 1) chk("e_ch1_off", 32'(CLK_OUT[1]), 32'h0);
    end
    chk("e_clk_after", 32'(CLK_OUT), 32'h0);

    // div=5, reload div=3 on the terminal-count edge
    LOAD = 1'b1; LOAD_CH = 2'd0; LOAD_DIV = 24'd5;
    cyc(1);
    LOAD = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("f_tick5 k=%0d", k), 32'(TICK[0]), 32'h0);
    end
    LOAD = 1'b1; LOAD_CH = 2'd0; LOAD_DIV = 24'd3;
    cyc(1);
    LOAD = 1'b0;
    chk("f_load_wins_tick", 32'(TICK[0]), 32'h0);
    chk("f_load_wins_clk", 32'(CLK_OUT[0]), 32'h0);
    chk("f_load_cnt", 32'(dut.g_ch[0].u_ch.cnt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk($sformatf("f_tick3 k=%0d", k), 32'(TICK[0]), 32'(k == 3));
    end
    chk("f_clk_toggle", 32'(CLK_OUT[0]), 32'h1);

    // Asynchronous reset mid-count with outputs high
    MODE = 3'b010; EN = 3'b011;
    cyc(1);
    chk("g_pre_tick", 32'(TICK), 32'b010);
    chk("g_pre_clk", 32'(CLK_OUT), 32'b011);
    #2 RST_N = 1'b0;
    #1;
    chk("g_async_tick", 32'(TICK), 32'h0);
    chk("g_async_clk", 32'(CLK_OUT), 32'h0);
    chk("g_async_err", 32'(LOAD_ERR), 32'h0);
    chk("g_div0", 32'(dut.g_ch[0].u_ch.div), 32'd100000);
    chk("g_div1", 32'(dut.g_ch[1].u_ch.div), 32'd100000);
    chk("g_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'd0);
    cyc(1);
    chk("g_held_clk", 32'(CLK_OUT), 32'h0);
    RST_N = 1'b1;
    cyc(3);
    chk("g_restart_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'd3);
    chk("g_restart_tick", 32'(TICK), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
